rx_packet_decoder: RTL

Downstream consumer of the UART receiver. Takes the byte stream (one-cycle `new_data` strobes) and finds framed packets: sync, length, payload and an optional checksum. It packs payload bytes into little-endian words and buffers them in a small FIFO behind a valid/ready interface. It also reports packet completion, framing errors and timeouts to the control logic.

---
 rtl/comms_pkg.sv | 14 +
 rtl/rx_packet_decoder_if.sv | 25 ++
 rtl/sync_fifo.sv | 54 +++++
 rtl/rx_packet_decoder.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/comms_pkg.sv
// rtl/comms_pkg.sv - shared types and constants for the packet receive path
package comms_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHECK
  } rx_state_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int CSUM_W = 8;

endpackage

// File: rtl/rx_packet_decoder_if.sv
// rtl/rx_packet_decoder_if.sv - packed-word output stream of the packet decoder
interface rx_packet_decoder_if #(
  parameter int WORD_BYTES = 4
);

  logic [8*WORD_BYTES-1:0] word_out;
  logic                    last_out;
  logic                    word_valid_out;
  logic                    word_ready_in;

  modport master (
    output word_out,
    output last_out,
    output word_valid_out,
    input  word_ready_in
  );

  modport slave (
    input  word_out,
    input  last_out,
    input  word_valid_out,
    output word_ready_in
  );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO; a push while full is refused even if a pop
// happens in the same cycle
module sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign wr_en = push & ~full;
  assign rd_en = pop & ~empty;

  // Head reads as zero while empty so the output is clean out of reset.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/rx_packet_decoder.sv
// rtl/rx_packet_decoder.sv - finds A5/LEN/payload frames in the UART byte stream and
// queues payload as little-endian words; RX_PACKET_CHECKSUM_EN adds a trailing sum byte
module rx_packet_decoder
  import comms_pkg::*;
#(
  parameter int         WORD_BYTES     = 4,
  parameter int         FIFO_DEPTH     = 8,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 10000
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic [7:0]                  data_in,
  input  logic                        new_data_in,
  rx_packet_decoder_if.master         word_if,
  output logic                        packet_done_out,
  output logic                        err_out,
  output logic                        busy_out
);

  localparam int WW = 8 * WORD_BYTES;
  localparam int BW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [BW-1:0] LAST_IDX = BW'(WORD_BYTES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  rx_state_e     state_q, state_d;
  logic [7:0]    rem_q, rem_d;
  logic [BW-1:0] bidx_q, bidx_d;
  logic [WW-1:0] pack_q, pack_d;
  logic          bad_q, bad_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          done_q, err_q;
`ifdef RX_PACKET_CHECKSUM_EN
  logic [CSUM_W-1:0] csum_q, csum_d;
`endif

  logic [WW-1:0] merged;
  logic          push;
  logic          push_last;
  logic          done_set;
  logic          err_set;
  logic          timeout;
  logic          final_byte;
  logic          fifo_full;
  logic          fifo_empty;
  logic [WW:0]   fifo_head;

  always_comb begin
    merged = pack_q;
    merged[{bidx_q, 3'b000} +: 8] = data_in;
  end

  assign final_byte = (rem_q == 8'd1);
  assign timeout    = (state_q != ST_IDLE) && !new_data_in && (tcnt_q == TO_LAST);

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    bidx_d    = bidx_q;
    pack_d    = pack_q;
    bad_d     = bad_q;
    tcnt_d    = (state_q == ST_IDLE || new_data_in) ? '0 : tcnt_q + 1'b1;
    push      = 1'b0;
    push_last = 1'b0;
    done_set  = 1'b0;
    err_set   = 1'b0;
`ifdef RX_PACKET_CHECKSUM_EN
    csum_d    = csum_q;
`endif

    if (timeout) begin
      state_d = ST_IDLE;
      pack_d  = '0;
      bidx_d  = '0;
      tcnt_d  = '0;
      err_set = 1'b1;
    end else if (new_data_in) begin
      case (state_q)
        ST_IDLE: begin
          if (data_in == SYNC_BYTE) begin
            state_d = ST_LEN;
            bad_d   = 1'b0;
            bidx_d  = '0;
            pack_d  = '0;
          end
        end
        ST_LEN: begin
          rem_d = data_in;
`ifdef RX_PACKET_CHECKSUM_EN
          csum_d = data_in;
`endif
          if (data_in != 8'd0) begin
            state_d = ST_PAYLOAD;
          end else begin
`ifdef RX_PACKET_CHECKSUM_EN
            state_d = ST_CHECK;
`else
            state_d  = ST_IDLE;
            done_set = 1'b1;
`endif
          end
        end
        ST_PAYLOAD: begin
          rem_d = rem_q - 8'd1;
`ifdef RX_PACKET_CHECKSUM_EN
          csum_d = csum_q + data_in;
`endif
          if (bidx_q == LAST_IDX || final_byte) begin
            push      = 1'b1;
            push_last = final_byte;
            pack_d    = '0;
            bidx_d    = '0;
            // A dropped word poisons the whole packet.
            if (fifo_full) begin
              err_set = 1'b1;
              bad_d   = 1'b1;
            end
          end else begin
            pack_d = merged;
            bidx_d = bidx_q + 1'b1;
          end
          if (final_byte) begin
`ifdef RX_PACKET_CHECKSUM_EN
            state_d = ST_CHECK;
`else
            state_d  = ST_IDLE;
            done_set = !(bad_q || fifo_full);
`endif
          end
        end
`ifdef RX_PACKET_CHECKSUM_EN
        ST_CHECK: begin
          state_d = ST_IDLE;
          if (csum_q + data_in != '0) err_set = 1'b1;
          else if (!bad_q)            done_set = 1'b1;
        end
`endif
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      bidx_q  <= '0;
      pack_q  <= '0;
      bad_q   <= 1'b0;
      tcnt_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      bidx_q  <= bidx_d;
      pack_q  <= pack_d;
      bad_q   <= bad_d;
      tcnt_q  <= tcnt_d;
      done_q  <= done_set;
      err_q   <= err_set;
    end
  end

`ifdef RX_PACKET_CHECKSUM_EN
  always_ff @(posedge clk_in) begin
    if (rst_in) csum_q <= '0;
    else        csum_q <= csum_d;
  end
`endif

  sync_fifo #(
    .WIDTH (WW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push      (push),
    .push_data ({push_last, merged}),
    .pop       (word_if.word_ready_in & ~fifo_empty),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign word_if.word_out       = fifo_head[WW-1:0];
  assign word_if.last_out       = fifo_head[WW];
  assign word_if.word_valid_out = ~fifo_empty;

  assign packet_done_out = done_q;
  assign err_out         = err_q;
  assign busy_out        = (state_q != ST_IDLE);

endmodule
